// File: rtl/noc_flit_pkg.sv
// ============================================================================
// Module   : noc_flit_pkg
// Brief    : Shared NoC flit format: width, type codes, header fields, parser states.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package noc_flit_pkg;

   localparam int FLIT_W = 34;

   localparam logic [1:0] FLIT_BODY    = 2'b00;
   localparam logic [1:0] FLIT_TAIL    = 2'b01;
   localparam logic [1:0] FLIT_HEADER  = 2'b10;
   localparam logic [1:0] FLIT_INVALID = 2'b11;

   localparam int HDR_RD_BIT   = 0;
   localparam int HDR_SRC_LSB  = 21;
   localparam int HDR_SRC_W    = 4;
   localparam int HDR_DEST_LSB = 25;
   localparam int HDR_DEST_W   = 4;
   localparam int HDR_VC_LSB   = 29;
   localparam int HDR_VC_W     = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BODY = 2'd1,
      ST_TAIL = 2'd2,
      ST_OUT  = 2'd3
   } parser_state_e;

   function automatic logic [1:0] flit_type(input logic [FLIT_W-1:0] flit);
      return flit[FLIT_W-1 -: 2];
   endfunction

endpackage

`default_nettype wire

// File: rtl/sna_flit_parser.sv
// ============================================================================
// Module   : sna_flit_parser
// Brief    : Slave-adapter parser turning header/body/tail flits into one
//            AXI4-Lite style request. Optional macro SNA_DEST_CHECK_EN drops
//            packets whose header dest differs from LOCAL_ADDR.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sna_flit_parser
   import noc_flit_pkg::*;
#(
   parameter logic [3:0] LOCAL_ADDR = 4'b0010
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FLIT_W-1:0] flit_in,
   input  logic              flit_valid,
   output logic              flit_ready,
   output logic              req_valid,
   input  logic              req_ready,
   output logic              req_write,
   output logic [31:0]       req_addr,
   output logic [31:0]       req_wdata,
   output logic [3:0]        req_src,
   output logic [2:0]        req_vc,
   output logic              err
);

   parser_state_e r_state;
   parser_state_e w_state_nxt;

   logic        r_drop;
   logic        r_write;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_src;
   logic [2:0]  r_vc;
   logic        r_err;

   logic        w_accept;
   logic [1:0]  w_type;
   logic        w_hdr_write;
   logic        w_dest_match;
   logic        w_drop_hdr;
   logic        w_err;
   logic        w_cap_hdr;
   logic        w_cap_body;
   logic        w_cap_tail;

   assign flit_ready   = (r_state != ST_OUT);
   assign req_valid    = (r_state == ST_OUT);
   assign w_accept     = flit_valid && flit_ready;
   assign w_type       = flit_type(flit_in);
   assign w_hdr_write  = ~flit_in[HDR_RD_BIT];
   assign w_dest_match = (flit_in[HDR_DEST_LSB +: HDR_DEST_W] == LOCAL_ADDR);

`ifdef SNA_DEST_CHECK_EN
   logic w_unused;
   assign w_drop_hdr = ~w_dest_match;
   assign w_unused   = ^flit_in[20:1];
`else
   logic w_unused;
   assign w_drop_hdr = 1'b0;
   assign w_unused   = ^{flit_in[20:1], w_dest_match};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Every accepted flit that does not fit the current state is an error and
   // sends the FSM back to IDLE; the offending flit is not reinterpreted.
   always_comb begin
      w_state_nxt = r_state;
      w_err       = 1'b0;
      w_cap_hdr   = 1'b0;
      w_cap_body  = 1'b0;
      w_cap_tail  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_type == FLIT_HEADER) begin
                  w_cap_hdr   = 1'b1;
                  w_state_nxt = w_hdr_write ? ST_BODY : ST_TAIL;
               end else begin
                  w_err = 1'b1;
               end
            end
         end
         ST_BODY: begin
            if (w_accept) begin
               if (w_type == FLIT_BODY) begin
                  w_cap_body  = 1'b1;
                  w_state_nxt = ST_TAIL;
               end else begin
                  w_err       = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_TAIL: begin
            if (w_accept) begin
               if (w_type == FLIT_TAIL) begin
                  w_cap_tail  = 1'b1;
                  w_state_nxt = r_drop ? ST_IDLE : ST_OUT;
               end else begin
                  w_err       = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_OUT: begin
            if (req_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Dropped packets never touch the visible request fields.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drop  <= 1'b0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_src   <= '0;
         r_vc    <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= w_err;
         if (w_cap_hdr) begin
            r_drop <= w_drop_hdr;
            if (!w_drop_hdr) begin
               r_write <= w_hdr_write;
               r_src   <= flit_in[HDR_SRC_LSB +: HDR_SRC_W];
               r_vc    <= flit_in[HDR_VC_LSB +: HDR_VC_W];
               r_addr  <= '0;
               r_wdata <= '0;
            end
         end
         if (w_cap_body && !r_drop) begin
            r_addr <= flit_in[31:0];
         end
         if (w_cap_tail && !r_drop) begin
            if (r_write) begin
               r_wdata <= flit_in[31:0];
            end else begin
               r_addr <= flit_in[31:0];
            end
         end
      end
   end

   assign req_write = r_write;
   assign req_addr  = r_addr;
   assign req_wdata = r_wdata;
   assign req_src   = r_src;
   assign req_vc    = r_vc;
   assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sna_flit_parser.sv
// ============================================================================
// Module   : tb_sna_flit_parser
// Brief    : Directed scoreboard bench for sna_flit_parser.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sna_flit_parser;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [33:0] flit_in = '0;
   logic        flit_valid = 1'b0;
   logic        flit_ready;
   logic        req_valid;
   logic        req_ready = 1'b1;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_src;
   logic [2:0]  req_vc;
   logic        err;

   sna_flit_parser #(.LOCAL_ADDR(4'b0010)) dut (
      .clk(clk), .rst(rst),
      .flit_in(flit_in), .flit_valid(flit_valid), .flit_ready(flit_ready),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_src(req_src), .req_vc(req_vc), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  src;
      logic [2:0]  vc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   n_err_seen = 0;
   int   exp_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations on each request handshake, checks hold stability.
   exp_t prev;
   bit   have_prev = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         have_prev = 1'b0;
      end else begin
         if (err) n_err_seen++;
         if (req_valid) begin
            chk("flit_ready_in_out", flit_ready, 1'b0);
            if (have_prev)
               chk("req_stable", {req_write, req_addr, req_wdata, req_src, req_vc}, prev);
            if (req_ready) begin
               have_prev = 1'b0;
               if (q.size() == 0) begin
                  chk("unexpected_req", req_valid, 1'b0);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  chk("req_write", req_write, e.wr);
                  chk("req_addr",  req_addr,  e.addr);
                  chk("req_wdata", req_wdata, e.wdata);
                  chk("req_src",   req_src,   e.src);
                  chk("req_vc",    req_vc,    e.vc);
               end
            end else begin
               prev      = {req_write, req_addr, req_wdata, req_src, req_vc};
               have_prev = 1'b1;
            end
         end else begin
            have_prev = 1'b0;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the flit is consumed.
   task automatic send_flit(input logic [33:0] f);
      int waited = 0;
      flit_in    = f;
      flit_valid = 1'b1;
      @(negedge clk);
      while (!flit_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!flit_ready) chk("flit_ready_timeout", flit_ready, 1'b1);
      @(posedge clk);
      #1;
      flit_valid = 1'b0;
      flit_in    = '0;
   endtask

   task automatic send_pkt(input logic [33:0] hdr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic wr,
                           input logic [3:0] src, input logic [2:0] vc,
                           input logic [3:0] dest);
      exp_t e;
      bit   deliver;
      deliver = 1'b1;
`ifdef SNA_DEST_CHECK_EN
      deliver = (dest == 4'b0010);
`endif
      e.wr    = wr;
      e.addr  = addr;
      e.wdata = wr ? wdata : 32'h0;
      e.src   = src;
      e.vc    = vc;
      if (deliver) q.push_back(e);
      send_flit(hdr);
      if (wr) send_flit({2'b00, addr});
      send_flit({2'b01, wr ? wdata : addr});
      @(negedge clk);
      chk("req_valid_latency", req_valid, deliver);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_flit_ready", flit_ready, 1'b1);
      chk("rst_req_valid",  req_valid,  1'b0);
      chk("rst_err",        err,        1'b0);
      chk("rst_fields", {req_write, req_addr, req_wdata, req_src, req_vc}, '0);
      @(posedge clk);
      #1;

      // Write: src 1, dest 0, vc 0, reserved bit set
      send_pkt(34'h2_0020_0200, 32'hA000_0010, 32'hDEAD_BEEF, 1'b1, 4'd1, 3'd0, 4'd0);
      // Read: src 4, dest 2, vc 5
      send_pkt(34'h2_A480_0001, 32'h1000_0004, 32'h0, 1'b0, 4'd4, 3'd5, 4'd2);
      // Read with every reserved bit set
      send_pkt(34'h0_041F_FFFF | 34'h2_0000_0000, 32'hFFFF_FFFC, 32'h0, 1'b0, 4'd0, 3'd0, 4'd2);

      // Backpressure: hold in OUT for 5 cycles while the next header waits
      req_ready = 1'b0;
      send_pkt(34'h2_64E0_0000, 32'h0000_1234, 32'hCAFE_F00D, 1'b1, 4'd7, 3'd3, 4'd2);
      fork
         send_pkt(34'h2_E5E0_0001, 32'h0000_0FFC, 32'h0, 1'b0, 4'd15, 3'd7, 4'd2);
         begin
            repeat (5) @(posedge clk);
            #1;
            req_ready = 1'b1;
         end
      join

      // Violations: tail in IDLE, header then header, invalid type in IDLE
      send_flit({2'b01, 32'h0000_0005});
      exp_err++;
      send_flit(34'h2_0420_0000);
      send_flit(34'h2_0420_0000);
      exp_err++;
      send_flit({2'b11, 32'h0});
      exp_err++;
      @(negedge clk);
      chk("idle_after_violation", {flit_ready, req_valid}, 2'b10);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("err_pulses", n_err_seen, exp_err);

      // Reset mid-packet after header and body
      send_flit(34'h2_0420_0000);
      send_flit({2'b00, 32'h7777_0000});
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_idle", {flit_ready, req_valid, err}, 3'b100);
      chk("midrst_fields", {req_write, req_addr, req_wdata, req_src, req_vc}, '0);
      send_pkt(34'h2_A480_0001, 32'h2000_0008, 32'h0, 1'b0, 4'd4, 3'd5, 4'd2);

      // Reset while a request is pending in OUT
      req_ready = 1'b0;
      send_pkt(34'h2_0420_0000 | 34'h0_2000_0000, 32'h4000_0000, 32'h5555_AAAA, 1'b1, 4'd1, 3'd1, 4'd2);
      rst = 1'b1;
      if (q.size() > 0) void'(q.pop_back());
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_ready = 1'b1;
      chk("outrst_no_valid", req_valid, 1'b0);
      chk("outrst_fields", {req_write, req_addr, req_wdata, req_src, req_vc}, '0);

      // Destination handling: dest 3 then dest 2
      send_pkt(34'h2_06A0_0000, 32'h3000_0000, 32'h1111_2222, 1'b1, 4'd5, 3'd0, 4'd3);
      send_pkt(34'h2_04A0_0000, 32'h3000_0004, 32'h3333_4444, 1'b1, 4'd5, 3'd0, 4'd2);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      chk("err_total", n_err_seen, exp_err);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
